// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode pipeline definitions.
//   INSTR_W, PC_W  : instruction word width and word-address (PC+1) width
//   fetch_bundle_t : packed {instr, pc4} pair handed from fetch to decode;
//                    also used by the decode-stage input latch
package fetch_queue_pkg;

    localparam int unsigned INSTR_W = 32;
    localparam int unsigned PC_W    = 30;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc4;
    } fetch_bundle_t;

endpackage

// File: rtl/fq_storage.sv
// Register array backing the fetch queue.
//   clock, reset : rising-edge clock, async active-high reset (clears array)
//   wr_en        : write wr_data into entry wr_addr on the rising edge
//   wr_addr      : write index
//   wr_data      : write payload
//   rd_addr      : read index (asynchronous read)
//   rd_data      : contents of entry rd_addr
module fq_storage #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 62,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [PTR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [PTR_W-1:0] rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// Decoupling FIFO between instruction fetch and decode.
// Holds {instr, PC+1} pairs; a redirect (flush) discards every entry.
//   clock, reset : rising-edge clock, async active-high reset
//   flush        : drop all entries and any concurrent push/pop
//   in_valid     : fetch presents in_instr/in_pc4
//   in_ready     : queue not full
//   in_instr     : fetched instruction
//   in_pc4       : word address of fetched instruction + 1
//   out_valid    : queue not empty; head presented on out_*
//   out_ready    : decode consumes the head this cycle
//   out_instr    : head instruction
//   out_pc4      : head PC+1
//   count        : occupancy, 0..DEPTH
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int unsigned DATA_W = INSTR_W,
    parameter  int unsigned ADDR_W = PC_W,
    parameter  int unsigned DEPTH  = 2,
    localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instr,
    input  logic [ADDR_W-1:0] in_pc4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instr,
    output logic [ADDR_W-1:0] out_pc4,
    output logic [PTR_W:0]    count
);

    localparam int unsigned  ENTRY_W    = DATA_W + ADDR_W;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic               push;
    logic               pop;
    logic [ENTRY_W-1:0] rd_data;

    // Flags depend on the count register only, so out_ready never reaches
    // in_ready combinationally; a full queue refuses a word even when a pop
    // happens in the same cycle.
    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    // DEPTH is a power of two, so natural pointer overflow is the wrap.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_storage (
        .clock   (clock),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (tail),
        .wr_data ({in_instr, in_pc4}),
        .rd_addr (head),
        .rd_data (rd_data)
    );

    assign out_instr = rd_data[ENTRY_W-1:ADDR_W];
    assign out_pc4   = rd_data[ADDR_W-1:0];

    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        count <= FULL_COUNT);

    a_no_pop_empty: assert property (@(posedge clock) disable iff (reset)
        pop |-> (count != '0));

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed bench for fetch_queue with a queue-based
// reference model and a negedge monitor comparing against its head.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int unsigned DEPTH = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [29:0] in_pc4 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [29:0] out_pc4;
    logic [1:0]  count;

    int unsigned checks = 0;
    int unsigned failures = 0;

    fetch_bundle_t exp_q[$];
    logic          mdl_push;

    fetch_queue #(
        .DATA_W (32),
        .ADDR_W (30),
        .DEPTH  (DEPTH)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc4    (in_pc4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc4   (out_pc4),
        .count     (count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO of bundles, updated from the rules
    // (full refuses, empty ignores out_ready, flush/reset empty it).
    always @(posedge clock or posedge reset) begin
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            mdl_push = in_valid && (exp_q.size() < DEPTH);
            if (out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
            if (mdl_push) exp_q.push_back(fetch_bundle_t'{instr: in_instr, pc4: in_pc4});
        end
    end

    // Monitor: compares flags and presented head with the model.
    always @(negedge clock) begin
        chk("count", 64'(count), 64'(exp_q.size()));
        chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(exp_q.size() < DEPTH));
        if (exp_q.size() > 0) begin
            chk("out_instr", 64'(out_instr), 64'(exp_q[0].instr));
            chk("out_pc4", 64'(out_pc4), 64'(exp_q[0].pc4));
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [29:0] pc,
                         input logic rdy, input logic fl);
        in_valid  = v;
        in_instr  = ins;
        in_pc4    = pc;
        out_ready = rdy;
        flush     = fl;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_idle();
        chk("idle_valid", 64'(out_valid), 64'd0);
        chk("idle_ready", 64'(in_ready), 64'd1);
        chk("idle_count", 64'(count), 64'd0);
        chk("idle_instr", 64'(out_instr), 64'd0);
        chk("idle_pc4", 64'(out_pc4), 64'd0);
    endtask

    initial begin
        logic [29:0] pc;

        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        chk_idle();

        // Single push, held by decode stall.
        drive(1'b1, 32'h8C220004, 30'h1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_instr", 64'(out_instr), 64'h8C220004);
            chk("hold_pc4", 64'(out_pc4), 64'h1);
            chk("hold_count", 64'(count), 64'd1);
            drive(1'b0, '0, '0, 1'b0, 1'b0);
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("drain_count", 64'(count), 64'd0);

        // Fill, refuse a third word, then drain in order.
        drive(1'b1, 32'h20010005, 30'h2, 1'b0, 1'b0);
        drive(1'b1, 32'h10220003, 30'h3, 1'b0, 1'b0);
        chk("full_ready", 64'(in_ready), 64'd0);
        chk("full_count", 64'(count), 64'd2);
        drive(1'b1, 32'hDEADBEEF, 30'h4, 1'b0, 1'b0);
        chk("refuse_count", 64'(count), 64'd2);
        chk("fifo_pc4_a", 64'(out_pc4), 64'h2);
        drive(1'b1, 32'hDEADBEEF, 30'h4, 1'b1, 1'b0);
        chk("full_pop_no_push", 64'(count), 64'd1);
        chk("fifo_pc4_b", 64'(out_pc4), 64'h3);
        chk("fifo_instr_b", 64'(out_instr), 64'h10220003);
        drive(1'b0, '0, '0, 1'b1, 1'b0);
        chk("fill_drained", 64'(count), 64'd0);

        // Streaming: push and pop every cycle.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, $urandom, 30'(i), 1'b1, 1'b0);
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_pc4", 64'(out_pc4), 64'(i));
        end
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Flush with concurrent push and pop.
        drive(1'b1, 32'h11111111, 30'h10, 1'b0, 1'b0);
        drive(1'b1, 32'h22222222, 30'h11, 1'b0, 1'b0);
        drive(1'b1, 32'h33333333, 30'h30, 1'b1, 1'b1);
        chk("flush_count", 64'(count), 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        drive(1'b1, 32'h0000AAAA, 30'h40, 1'b0, 1'b0);
        chk("post_flush_pc4", 64'(out_pc4), 64'h40);
        chk("post_flush_instr", 64'(out_instr), 64'h0000AAAA);
        drive(1'b0, '0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-cycle with the queue full.
        drive(1'b1, 32'h44444444, 30'h20, 1'b0, 1'b0);
        drive(1'b0, 32'h55555555, 30'h21, 1'b0, 1'b0);
        drive(1'b1, 32'h55555555, 30'h21, 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("pre_reset_count", 64'(count), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("areset_count", 64'(count), 64'd0);
        chk("areset_valid", 64'(out_valid), 64'd0);
        chk("areset_instr", 64'(out_instr), 64'd0);
        chk("areset_ready", 64'(in_ready), 64'd1);
        @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        chk_idle();

        // Randomized traffic.
        pc = 30'h100;
        for (int i = 0; i < 600; i++) begin
            drive(($urandom_range(0, 3) != 0), $urandom, pc,
                  ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
            pc = pc + 30'd1;
        end

        @(negedge clock);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
